// File: rtl/if_id_fifo.sv
// ---------------------------------------------------------------------------
// if_id_fifo
//
// Decoupling buffer between the fetch (IF) and decode (ID) stages. It holds
// up to DEPTH (pc, inst) pairs, so fetch can run ahead while decode is stalled.
// Both sides use a valid/ready handshake. A synchronous flush discards every
// held entry when a branch or exception redirects the stream.
//
// The head entry is presented directly from storage (first-word fall-through),
// with no same-cycle bypass. When the buffer is empty, decode sees a bubble:
// valid_id=0 and pc_id/inst_id are forced to zero.
//
// Parameters:
//   ADDR_W  width of pc fields
//   DATA_W  width of instruction fields
//   DEPTH   number of entries (power of two, >= 2)
//   CNT_W   width of the occupancy count
//
// Ports:
//   clk        clock; all state updates on its rising edge
//   reset_     asynchronous, active-high reset
//   flush      synchronous discard of all entries
//   pc_if      pc of incoming fetch
//   inst_if    incoming instruction
//   valid_if   fetch presents a valid pair
//   ready_if   buffer can accept this cycle
//   pc_id      pc at head of buffer (0 when empty)
//   inst_id    instruction at head of buffer (0 when empty)
//   valid_id   head entry valid
//   ready_id   decode consumes the head this cycle
//   count      current number of valid entries
//   stall_cnt  (only with IF_ID_FIFO_STALL_CNT_EN) saturating count of
//              cycles where fetch was back-pressured (valid_if & ~ready_if)
//
// Optional feature macro: IF_ID_FIFO_STALL_CNT_EN
// ---------------------------------------------------------------------------
module if_id_fifo #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              flush,
  input  logic [ADDR_W-1:0] pc_if,
  input  logic [DATA_W-1:0] inst_if,
  input  logic              valid_if,
  output logic              ready_if,
  output logic [ADDR_W-1:0] pc_id,
  output logic [DATA_W-1:0] inst_id,
  output logic              valid_id,
  input  logic              ready_id,
  output logic [CNT_W-1:0]  count
`ifdef IF_ID_FIFO_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] inst_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              push;
  logic              pop;

  // Flow control depends only on the registered count. Consequently, a pop in
  // the same cycle cannot open a slot for a push while the buffer is full.
  assign ready_if = (count != CNT_W'(DEPTH));
  assign valid_id = (count != '0);

  // A flush overrides both handshakes. Any pair offered during a flush is dropped.
  assign push = valid_if & ready_if & ~flush;
  assign pop  = valid_id & ready_id & ~flush;

  // Zero the head outputs when the buffer is empty so stale storage never leaks.
  assign pc_id   = valid_id ? pc_mem[rd_ptr]   : '0;
  assign inst_id = valid_id ? inst_mem[rd_ptr] : '0;

  // NOTE: sequential state uses non-blocking assignments. Every register then
  // samples pre-edge values, and the order of the statements does not matter.
  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally on overflow.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately left without a reset. Validity
  // is tracked entirely by count, and the bubble mux hides stale data. This
  // lets the array map onto plain flops or RAM without a reset network.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= pc_if;
      inst_mem[wr_ptr] <= inst_if;
    end
  end

`ifdef IF_ID_FIFO_STALL_CNT_EN
  // Counts fetch back-pressure cycles and saturates at all-ones. Only reset
  // clears it, so the count survives a redirect.
  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      stall_cnt <= '0;
    end else if (valid_if && !ready_if && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_fifo.sv
// ---------------------------------------------------------------------------
// tb_if_id_fifo
//
// Directed bench for if_id_fifo with DEPTH=4. Each accepted push is recorded
// in an expected queue. A monitor running on the falling edge pops that queue
// whenever decode consumes the head, and compares the pair. The monitor also
// checks that an empty buffer shows zeroed outputs. The main sequence checks
// count, ready, valid and head values directly, #1 after each rising edge.
// ---------------------------------------------------------------------------
module tb_if_id_fifo;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset_ = 1'b0;
  logic              flush = 1'b0;
  logic [ADDR_W-1:0] pc_if = '0;
  logic [DATA_W-1:0] inst_if = '0;
  logic              valid_if = 1'b0;
  logic              ready_if;
  logic [ADDR_W-1:0] pc_id;
  logic [DATA_W-1:0] inst_id;
  logic              valid_id;
  logic              ready_id = 1'b0;
  logic [CNT_W-1:0]  count;
`ifdef IF_ID_FIFO_STALL_CNT_EN
  logic [31:0]       stall_cnt;
`endif

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } pair_t;

  pair_t exp_q[$];
  pair_t mon_e;
  int    vectors     = 0;
  int    miscompares = 0;

  if_id_fifo #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .reset_   (reset_),
    .flush    (flush),
    .pc_if    (pc_if),
    .inst_if  (inst_if),
    .valid_if (valid_if),
    .ready_if (ready_if),
    .pc_id    (pc_id),
    .inst_id  (inst_id),
    .valid_id (valid_id),
    .ready_id (ready_id),
    .count    (count)
`ifdef IF_ID_FIFO_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [31:0] p, input logic [31:0] i,
                     input logic r, input logic f);
    valid_if = v;
    pc_if    = p;
    inst_if  = i;
    ready_id = r;
    flush    = f;
  endtask

  task automatic expect_push(input logic [31:0] p, input logic [31:0] i);
    exp_q.push_back({p, i});
  endtask

  // Reset asserts between clock edges, and the bench then checks the
  // asynchronous reset values.
  task automatic pulse_reset(input string tag);
    drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2 reset_ = 1'b1;
    #1;
    check({tag, "_count"},    64'(count),    64'h0);
    check({tag, "_valid_id"}, 64'(valid_id), 64'h0);
    check({tag, "_pc_id"},    64'(pc_id),    64'h0);
    check({tag, "_inst_id"},  64'(inst_id),  64'h0);
    check({tag, "_ready_if"}, 64'(ready_if), 64'h1);
    exp_q.delete();
    step();
    reset_ = 1'b0;
  endtask

  // Scoreboard monitor. Its inputs settle at posedge+1, so at the falling edge
  // it sees the handshake that the next rising edge will act on.
  always @(negedge clk) begin
    if (!reset_) begin
      if (valid_id && ready_id && !flush) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL pop_unexpected: got pc %h, expected no valid entry", pc_id);
        end else begin
          mon_e = exp_q.pop_front();
          check("pop_pc",   64'(pc_id),   64'(mon_e.pc));
          check("pop_inst", 64'(inst_id), 64'(mon_e.inst));
        end
      end
      if (!valid_id) check("bubble", {pc_id, inst_id}, 64'h0);
    end
  end

  // Watchdog: stops the run if the sequence never completes.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of sequence");
    $fatal(1, "timeout");
  end

  logic [31:0] fill_pc   [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
  logic [31:0] fill_inst [4] = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00300193};

  initial begin
    // ---- Power-on reset ----
    #1 reset_ = 1'b1;
    #2;
    check("por_count",    64'(count),    64'h0);
    check("por_valid_id", 64'(valid_id), 64'h0);
    check("por_ready_if", 64'(ready_if), 64'h1);
    step();
    reset_ = 1'b0;

    // ---- Reset mid-stream ----
    drv(1'b1, 32'h100, 32'h24010001, 1'b0, 1'b0);
    expect_push(32'h100, 32'h24010001);
    step();
    check("mid_valid_pre", 64'(valid_id), 64'h1);
    check("mid_pc_pre",    64'(pc_id),    64'h100);
    pulse_reset("mid_rst");

    // ---- Fill and drain ----
    for (int k = 0; k < 4; k++) begin
      drv(1'b1, fill_pc[k], fill_inst[k], 1'b0, 1'b0);
      expect_push(fill_pc[k], fill_inst[k]);
      step();
      check("fill_count", 64'(count), 64'(k + 1));
    end
    check("fill_ready_if", 64'(ready_if), 64'h0);
    drv(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0);   // rejected: buffer full
    step();
    check("fill_5th_count", 64'(count), 64'h4);
    check("fill_head_pc",   64'(pc_id), 64'h0);
    for (int k = 0; k < 4; k++) begin
      drv(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step();
      check("drain_count", 64'(count), 64'(3 - k));
    end
    check("drain_valid_id", 64'(valid_id), 64'h0);
    check("drain_pc_id",    64'(pc_id),    64'h0);

    // ---- Single-entry latency and steady push/pop across wrap ----
    drv(1'b1, 32'h200, 32'h00000200, 1'b0, 1'b0);
    expect_push(32'h200, 32'h00000200);
    #1;
    check("lat_no_bypass", 64'(valid_id), 64'h0);
    step();
    check("lat_valid_id", 64'(valid_id), 64'h1);
    check("lat_pc_id",    64'(pc_id),    64'h200);
    for (int k = 0; k < 10; k++) begin
      drv(1'b1, 32'h204 + 32'(4 * k), 32'h00000204 + 32'(4 * k), 1'b1, 1'b0);
      expect_push(32'h204 + 32'(4 * k), 32'h00000204 + 32'(4 * k));
      step();
      check("stream_count", 64'(count), 64'h1);
      check("stream_pc",    64'(pc_id), 64'(32'h204 + 32'(4 * k)));
    end
    drv(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    check("stream_end_count", 64'(count), 64'h0);

    // ---- Flush priority ----
    drv(1'b1, 32'h40, 32'h00000040, 1'b0, 1'b0);
    expect_push(32'h40, 32'h00000040);
    step();
    drv(1'b1, 32'h44, 32'h00000044, 1'b0, 1'b0);
    expect_push(32'h44, 32'h00000044);
    step();
    check("flush_pre_count", 64'(count), 64'h2);
    drv(1'b1, 32'h1000, 32'h00001000, 1'b1, 1'b1);
    exp_q.delete();
    step();
    check("flush_count",    64'(count),    64'h0);
    check("flush_valid_id", 64'(valid_id), 64'h0);
    drv(1'b1, 32'h1000, 32'h00001000, 1'b0, 1'b0);
    expect_push(32'h1000, 32'h00001000);
    step();
    check("post_flush_valid", 64'(valid_id), 64'h1);
    check("post_flush_pc",    64'(pc_id),    64'h1000);
    drv(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();

    // ---- Full with simultaneous pop ----
    for (int k = 0; k < 4; k++) begin
      drv(1'b1, 32'h300 + 32'(4 * k), 32'hA0000000 + 32'(k), 1'b0, 1'b0);
      expect_push(32'h300 + 32'(4 * k), 32'hA0000000 + 32'(k));
      step();
    end
    check("full_count", 64'(count), 64'h4);
    drv(1'b1, 32'h310, 32'hA0000004, 1'b1, 1'b0);   // pop accepted, push rejected
    #1;
    check("full_pop_ready_if", 64'(ready_if), 64'h0);
    step();
    check("full_pop_count",   64'(count),    64'h3);
    check("full_pop_ready_1", 64'(ready_if), 64'h1);
    for (int k = 0; k < 3; k++) begin
      drv(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step();
    end
    check("full_drain_count", 64'(count), 64'h0);

`ifdef IF_ID_FIFO_STALL_CNT_EN
    // ---- Stall counter ----
    pulse_reset("stall_rst");
    check("stall_init", 64'(stall_cnt), 64'h0);
    for (int k = 0; k < 4; k++) begin
      drv(1'b1, 32'h500 + 32'(4 * k), 32'hB0000000 + 32'(k), 1'b0, 1'b0);
      expect_push(32'h500 + 32'(4 * k), 32'hB0000000 + 32'(k));
      step();
    end
    check("stall_fill_zero", 64'(stall_cnt), 64'h0);
    drv(1'b1, 32'h510, 32'hB0000004, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) step();
    drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("stall_seven", 64'(stall_cnt), 64'h7);
    drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    exp_q.delete();
    step();
    drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("stall_after_flush", 64'(stall_cnt), 64'h7);
    check("stall_flush_count", 64'(count),     64'h0);
    pulse_reset("stall_rst2");
    check("stall_after_reset", 64'(stall_cnt), 64'h0);
`endif

    check("queue_empty", 64'(exp_q.size()), 64'h0);
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
